// File: rtl/calc_sequencer.sv
// Accumulator-based micro-sequencer: runs a 16-word program held in local memory,
// stepping an external address counter through CLEAR/FETCH/EXEC until HALT or the last word.
module calc_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [3:0] address,
  output logic       cnt_en,
  output logic       ctr_clr,
  output logic [7:0] acc,
  output logic       carry,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, EXEC, DONE} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [7:0]  mem [16];
  logic [7:0]  ir;
  logic [7:0]  fetch_word;
  logic        fetch_is_last;
  logic [7:0]  imm;
  logic [8:0]  sum;
  logic        exec_is_last;

  // Asynchronous read at the address the external counter is presenting.
  assign fetch_word    = mem[address];
  assign fetch_is_last = (fetch_word[7:4] == OP_HALT) || (address == 4'hF);
  assign exec_is_last  = (ir[7:4] == OP_HALT) || (address == 4'hF);
  assign imm           = {4'h0, ir[3:0]};
  assign sum           = {1'b0, acc} + {1'b0, imm};

  // NOTE: all state below is sequential, so every assignment is non-blocking;
  // the outputs are registered one state ahead so they are glitch-free in their state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= 8'h00;
      carry   <= 1'b0;
      ir      <= 8'h00;
      cnt_en  <= 1'b0;
      ctr_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      // NOTE: the program memory is cleared by reset, so it is built from plain
      // flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      cnt_en  <= 1'b0;
      ctr_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (prog_we) mem[prog_addr] <= prog_data;
          if (start) begin
            state   <= CLEAR;
            ctr_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CLEAR: state <= FETCH;
        FETCH: begin
          ir     <= fetch_word;
          cnt_en <= ~fetch_is_last;
          state  <= EXEC;
        end
        EXEC: begin
          case (ir[7:4])
            OP_LOAD: begin acc <= imm; carry <= 1'b0; end
            OP_ADD:  {carry, acc} <= sum;
            OP_SUB:  begin acc <= acc - imm; carry <= (imm > acc); end
            OP_AND:  acc <= acc & imm;
            OP_OR:   acc <= acc | imm;
            OP_XOR:  acc <= acc ^ imm;
            OP_SHL:  begin carry <= acc[7]; acc <= {acc[6:0], 1'b0}; end
            OP_SHR:  begin carry <= acc[0]; acc <= {1'b0, acc[7:1]}; end
            OP_NOP:  ;
            default: ;
          endcase
          if (exec_is_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: emulates the external address counter and compares the DUT
// against a program-level reference interpreter for directed and random programs.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, prog_we;
  logic [3:0] prog_addr, address;
  logic [7:0] prog_data, acc;
  logic       cnt_en, ctr_clr, carry, busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  int m_mem [16];
  int m_acc, m_carry;

  always #5 clock = ~clock;

  calc_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .address(address),
    .cnt_en(cnt_en), .ctr_clr(ctr_clr), .acc(acc), .carry(carry),
    .busy(busy), .done(done)
  );

  // External program counter driven by the DUT's requests.
  always @(posedge clock) begin
    if (reset)        address <= 4'h0;
    else if (ctr_clr) address <= 4'h0;
    else if (cnt_en)  address <= address + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int a, input int d);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = a[3:0];
    prog_data = d[7:0];
    @(negedge clock);
    prog_we   = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_acc   = 0;
    m_carry = 0;
  endtask

  // Interprets the program in m_mem; returns instructions executed and counter advances.
  task automatic model_run(output int n, output int pulses);
    int pc, op, imm;
    pc = 0; n = 0; pulses = 0;
    while (1) begin
      op  = m_mem[pc] / 16;
      imm = m_mem[pc] % 16;
      n++;
      case (op)
        1: begin m_acc = imm; m_carry = 0; end
        2: begin m_carry = (m_acc + imm > 255); m_acc = (m_acc + imm) % 256; end
        3: begin m_carry = (imm > m_acc); m_acc = (m_acc - imm + 256) % 256; end
        4: m_acc = m_acc & imm;
        5: m_acc = m_acc | imm;
        6: m_acc = m_acc ^ imm;
        7: begin m_carry = m_acc / 128; m_acc = (m_acc * 2) % 256; end
        8: begin m_carry = m_acc % 2; m_acc = m_acc / 2; end
        default: ;
      endcase
      if (op == 15 || pc == 15) break;
      pulses++;
      pc++;
    end
  endtask

  // Cycle k=1 is the cycle after the edge that samples start (CLEAR).
  task automatic run_prog(input string tag, input bit mid_we, input bit mid_start);
    int  n, pulses, k, cnt, clr, busy_low;
    bit  seen;
    model_run(n, pulses);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    check({tag, "_clear_cnt_en"}, {31'd0, cnt_en}, 0);
    k = 1; cnt = 0; clr = 0; busy_low = 0; seen = 0;
    while (k <= 60) begin
      if (done) begin seen = 1; break; end
      cnt += int'(cnt_en);
      clr += int'(ctr_clr);
      if (!busy) busy_low++;
      if (mid_we && k == 3) begin
        prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hF0;
      end
      if (mid_start && k == 4) start = 1'b1;
      @(negedge clock);
      prog_we = 1'b0;
      start   = 1'b0;
      k++;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 1);
    check({tag, "_latency"},   k, 2 + 2 * n);
    check({tag, "_cnt_en"},    cnt, pulses);
    check({tag, "_ctr_clr"},   clr, 1);
    check({tag, "_busy_gap"},  busy_low, 0);
    check({tag, "_busy_done"}, {31'd0, busy}, 0);
    check({tag, "_acc"},       {24'd0, acc}, m_acc);
    check({tag, "_carry"},     {31'd0, carry}, m_carry);
    @(negedge clock);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
    check({tag, "_acc_hold"},   {24'd0, acc}, m_acc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'h0; prog_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    // Reset must win over a simultaneous start and write.
    @(negedge clock);
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h1F;
    @(negedge clock);
    check("rst_busy",    {31'd0, busy}, 0);
    check("rst_done",    {31'd0, done}, 0);
    check("rst_cnt_en",  {31'd0, cnt_en}, 0);
    check("rst_ctr_clr", {31'd0, ctr_clr}, 0);
    check("rst_acc",     {24'd0, acc}, 0);
    check("rst_carry",   {31'd0, carry}, 0);
    reset = 1'b0; start = 1'b0; prog_we = 1'b0;

    // Empty memory: runs to address 15 without wrapping.
    run_prog("empty", 0, 0);
    check("empty_addr", {28'd0, address}, 15);

    write_word(0, 8'h15); write_word(1, 8'h23); write_word(2, 8'h70); write_word(3, 8'hF0);
    run_prog("basic", 0, 0);
    check("basic_acc_const", {24'd0, acc}, 32'h10);

    write_word(0, 8'h1F); write_word(1, 8'h70); write_word(2, 8'h70); write_word(3, 8'h70);
    write_word(4, 8'h70); write_word(5, 8'h2F); write_word(6, 8'h21); write_word(7, 8'hF0);
    run_prog("shl_add", 0, 0);
    check("shl_add_acc_const",   {24'd0, acc}, 32'h00);
    check("shl_add_carry_const", {31'd0, carry}, 1);

    write_word(0, 8'h12); write_word(1, 8'h35); write_word(2, 8'hF0);
    run_prog("sub", 0, 0);
    check("sub_acc_const", {24'd0, acc}, 32'hFD);
    write_word(2, 8'h9A); write_word(3, 8'hF0);
    run_prog("undef_op", 0, 0);
    check("undef_acc_const",   {24'd0, acc}, 32'hFD);
    check("undef_carry_const", {31'd0, carry}, 1);

    // Writes and start pulses while busy must be ignored.
    write_word(0, 8'h11); write_word(1, 8'h21); write_word(2, 8'h21);
    write_word(3, 8'h21); write_word(4, 8'hF0);
    run_prog("busy_we", 1, 1);
    check("busy_we_acc_const", {24'd0, acc}, 32'h04);

    for (int it = 0; it < 14; it++) begin
      int len;
      len = int'($urandom_range(1, 16));
      for (int a = 0; a < len; a++) write_word(a, int'($urandom_range(0, 255)));
      run_prog($sformatf("rand%0d", it), it[0], it[1]);
    end

    // Reset in the EXEC of the second instruction aborts the program.
    write_word(0, 8'h15); write_word(1, 8'h23); write_word(2, 8'hF0);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_exec2_cnt_en", {31'd0, cnt_en}, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy",   {31'd0, busy}, 0);
    check("abort_done",   {31'd0, done}, 0);
    check("abort_cnt_en", {31'd0, cnt_en}, 0);
    check("abort_acc",    {24'd0, acc}, 0);
    check("abort_carry",  {31'd0, carry}, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("abort_no_done", {31'd0, done}, 0);
    run_prog("after_abort", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
